// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input valid/ready stream multiplexer with one registered
// output stage. Arbitration is either an explicit channel select or
// round-robin across requesting inputs, fixed by RR_MODE.
module stream_mux_rr #(
  parameter int WIDTH   = 32,
  parameter int N_IN    = 4,
  parameter int RR_MODE = 0,
  parameter int SEL_W   = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_src
);

  logic             load_en;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic [SEL_W-1:0] ptr;
  logic             xfer;

  // Output register can take a beat when empty or while its beat is popped.
  assign load_en = !out_valid || out_ready;

  // Pick the granted channel. In round-robin mode the loop runs from the
  // farthest candidate to the nearest, so the one closest to ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (RR_MODE != 0) begin
      for (int k = N_IN - 1; k >= 0; k--) begin
        for (int i = 0; i < N_IN; i++) begin
          if (in_valid[i] && (i == ((int'(ptr) + k) % N_IN))) begin
            gnt_vld = 1'b1;
            gnt_idx = SEL_W'(i);
          end
        end
      end
    end else begin
      // Out-of-range sel matches no channel, so it simply never grants.
      for (int i = 0; i < N_IN; i++) begin
        if (in_valid[i] && (int'(sel) == i)) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end
  end

  // Route the granted channel's data and raise exactly its ready bit.
  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (int'(gnt_idx) == i) begin
        gnt_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = rst_n && load_en && gnt_vld;
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  // Output stage and round-robin pointer; ptr only moves on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_src   <= gnt_idx;
      if (RR_MODE != 0) begin
        if (int'(gnt_idx) == N_IN - 1) ptr <= '0;
        else                           ptr <= gnt_idx + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
